pe_stream_feeder: RTL and testbench

- Transmit-side controller for the 8-lane pipelined PE (multiply plus 3-level adder tree, 5 register stages).
- Accepts a valid/ready stream of 8-lane beats, each beat being 8×2-bit activations and 8×16-bit weights.
- Drives the PE ports with correct activation/weight alignment and tracks in-flight beats.
- Accumulates CHUNKS PE results into one neuron output and emits it on a valid/ready result port; stalls the PE under backpressure.

---
 rtl/pe_stream_feeder.sv | 169 ++++++++++++++++
 tb/tb_pe_stream_feeder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder: transmit-side controller for the 8-lane pipelined PE
// (multiply + 3-level adder tree, PE_LAT register stages).
//
// Takes a valid/ready stream of beats (8 x 2-bit activations, 8 x 16-bit
// weights), feeds the PE with weights delayed one cycle behind their
// activations, and tracks every beat in flight with a {valid,last} tag that
// walks alongside the PE pipeline.
//
// Every CHUNKS PE results are summed (mod 2^16) into one neuron output, which
// is presented on m_data/m_index with m_valid. The whole PE pipeline and this
// controller freeze while a result is held under backpressure.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clear             soft abort, flushes all in-flight state
//   s_valid/s_ready   input beat handshake; s_act[2i+1:2i], s_wgt[16i+15:16i]
//   pe_en, pe_clr     PE pipeline enable / synchronous clear
//   pe_act, pe_wgt    PE activation / weight inputs
//   pe_out            PE result
//   m_valid/m_ready   result handshake; m_data neuron sum, m_index neuron number
//   busy              beats in flight, partial neuron, or result pending

// Per-lane datapath: activation gated to zero on bubbles, weight registered so
// it reaches the PE's multiplier in the same cycle as the registered activation.
module pe_feed_lane #(
    parameter int ACT_W = 2,
    parameter int VEC_W = 16
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             adv,
    input  logic             accept,
    input  logic [ACT_W-1:0] s_act,
    input  logic [VEC_W-1:0] s_wgt,
    output logic [ACT_W-1:0] pe_act,
    output logic [VEC_W-1:0] pe_wgt
);
    logic [VEC_W-1:0] wgt_q;

    assign pe_act = accept ? s_act : '0;
    assign pe_wgt = wgt_q;

    // Held while the PE is stalled so the frozen stage-1 activation keeps its
    // matching weight.
    always_ff @(posedge clk) begin
        if (flush)
            wgt_q <= '0;
        else if (adv)
            wgt_q <= accept ? s_wgt : '0;
    end
endmodule

module pe_stream_feeder #(
    parameter int CHUNKS = 4,
    parameter int PE_LAT = 5,
    parameter int IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [15:0]      s_act,
    input  logic [127:0]     s_wgt,
    output logic             pe_en,
    output logic             pe_clr,
    output logic [15:0]      pe_act,
    output logic [127:0]     pe_wgt,
    input  logic [15:0]      pe_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic [IDX_W-1:0] m_index,
    output logic             busy
);
    localparam int NUM_LANES = 8;
    localparam int ACT_W     = 2;
    localparam int VEC_W     = 16;
    localparam int CNT_W     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

    logic adv, accept, flush, last_in, fire;
    logic [CNT_W-1:0]  cnt;
    logic [PE_LAT-1:0] vld_pipe;
    logic [PE_LAT-1:0] last_pipe;
    logic [15:0]       acc, sum;
    logic [IDX_W-1:0]  idx_cnt;

    logic [NUM_LANES-1:0][ACT_W-1:0] act_in, act_pe;
    logic [NUM_LANES-1:0][VEC_W-1:0] wgt_in, wgt_pe;

    // The only stall source is a held result: everything advances otherwise.
    assign adv     = !(m_valid && !m_ready);
    assign pe_en   = adv;
    assign pe_clr  = rst || clear;
    assign flush   = rst || clear;
    assign s_ready = adv && !clear && !rst;
    assign accept  = s_valid && s_ready;
    assign last_in = (cnt == CNT_LAST);

    // Oldest tag lines up with the PE output for the same beat.
    assign fire = adv && vld_pipe[PE_LAT-1];
    assign sum  = (CHUNKS == 1) ? pe_out : acc + pe_out;
    assign busy = (|vld_pipe) || (cnt != '0) || m_valid;

    assign act_in = s_act;
    assign wgt_in = s_wgt;
    assign pe_act = act_pe;
    assign pe_wgt = wgt_pe;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pe_feed_lane #(
            .ACT_W (ACT_W),
            .VEC_W (VEC_W)
        ) u_lane (
            .clk    (clk),
            .flush  (flush),
            .adv    (adv),
            .accept (accept),
            .s_act  (act_in[i]),
            .s_wgt  (wgt_in[i]),
            .pe_act (act_pe[i]),
            .pe_wgt (wgt_pe[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            acc       <= '0;
            m_valid   <= 1'b0;
            idx_cnt   <= '0;
            m_index   <= '0;
            if (rst)
                m_data <= '0;
        end else begin
            if (accept)
                cnt <= last_in ? '0 : cnt + CNT_W'(1);

            if (adv) begin
                vld_pipe[0]  <= accept;
                last_pipe[0] <= accept && last_in;
                for (int k = 1; k < PE_LAT; k++) begin
                    vld_pipe[k]  <= vld_pipe[k-1];
                    last_pipe[k] <= last_pipe[k-1];
                end
            end

            if (fire) begin
                if (last_pipe[PE_LAT-1]) begin
                    m_data  <= sum;
                    m_index <= idx_cnt;
                    idx_cnt <= idx_cnt + IDX_W'(1);
                    acc     <= '0;
                end else begin
                    acc <= sum;
                end
            end

            // A new result replaces a consumed one in the same cycle (no bubble).
            if (fire && last_pipe[PE_LAT-1])
                m_valid <= 1'b1;
            else if (m_ready)
                m_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_stream_feeder.sv
// Bench for pe_stream_feeder with a behavioural 5-stage PE model: stage 1
// registers activations, stage 2 registers the dot product with the live
// pe_wgt, stages 3..5 are delay. Misaligned weights show up as wrong sums.
module tb_pe_stream_feeder;
    localparam int IDX_W = 8;

    logic clk = 1'b0;
    logic rst, clear, s_valid, m_ready;
    logic s_ready, pe_en, pe_clr, m_valid, busy;
    logic [15:0]      s_act, pe_act, pe_out, m_data;
    logic [127:0]     s_wgt, pe_wgt;
    logic [IDX_W-1:0] m_index;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pe_stream_feeder #(.CHUNKS(4), .PE_LAT(5), .IDX_W(IDX_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_act   (s_act),
        .s_wgt   (s_wgt),
        .pe_en   (pe_en),
        .pe_clr  (pe_clr),
        .pe_act  (pe_act),
        .pe_wgt  (pe_wgt),
        .pe_out  (pe_out),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .busy    (busy)
    );

    // PE model
    logic [15:0] pa_q, p2, p3, p4, p5;

    function automatic logic [15:0] dot(input logic [15:0] a, input logic [127:0] w);
        logic [15:0] s;
        s = 16'h0;
        for (int i = 0; i < 8; i++)
            s = s + 16'(16'(a[2*i +: 2]) * w[16*i +: 16]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (pe_clr) begin
            pa_q <= '0; p2 <= '0; p3 <= '0; p4 <= '0; p5 <= '0;
        end else if (pe_en) begin
            pa_q <= pe_act;
            p2   <= dot(pa_q, pe_wgt);
            p3   <= p2;
            p4   <= p3;
            p5   <= p4;
        end
    end
    assign pe_out = p5;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] a, input logic [127:0] w);
        s_valid = 1'b1; s_act = a; s_wgt = w;
    endtask

    task automatic idle();
        s_valid = 1'b0; s_act = '0; s_wgt = '0;
    endtask

    task automatic do_clear();
        idle();
        clear = 1'b1;
        nxt();
        clear = 1'b0;
    endtask

    // Four back-to-back beats from t=0 with m_ready=1: result visible at t=9 only.
    task automatic one_neuron(input string tag, input logic [127:0] w,
                              input logic [15:0] exp_d, input logic [IDX_W-1:0] exp_i);
        for (int t = 0; t < 13; t++) begin
            if (t < 4) beat(16'h0001, w); else idle();
            @(negedge clk);
            chk($sformatf("%s_vld_t%0d", tag, t), 32'(m_valid), 32'(t == 9));
            if (t == 9) begin
                chk({tag, "_data"}, 32'(m_data), 32'(exp_d));
                chk({tag, "_idx"}, 32'(m_index), 32'(exp_i));
            end
            nxt();
        end
    endtask

    initial begin
        int k;
        rst = 1'b1; clear = 1'b0; m_ready = 1'b1;
        idle();
        repeat (3) nxt();

        // reset state
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data",  32'(m_data), 0);
        chk("rst_m_index", 32'(m_index), 0);
        chk("rst_pe_wgt",  32'(|pe_wgt), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_pe_clr",  32'(pe_clr), 1);
        nxt();
        rst = 1'b0;

        // alignment: weights one cycle behind activations
        beat(16'h5555, 128'h0100);
        @(negedge clk);
        chk("aln_s_ready", 32'(s_ready), 1);
        chk("aln_act_T", 32'(pe_act), 32'h5555);
        nxt(); idle();
        @(negedge clk);
        chk("aln_act_T1", 32'(pe_act), 0);
        chk("aln_wgt_T1", 32'(pe_wgt[15:0]), 32'h0100);
        chk("aln_wgt_T1_hi", 32'(|pe_wgt[127:16]), 0);
        nxt();
        @(negedge clk);
        chk("aln_wgt_T2", 32'(|pe_wgt), 0);
        nxt();
        do_clear();

        // latency / accumulate
        one_neuron("lat", 128'h0010, 16'h0040, 0);

        // continuous stream of 8 beats
        do_clear();
        for (int t = 0; t < 20; t++) begin
            if (t < 8) beat(16'h0001, 128'h0010); else idle();
            @(negedge clk);
            if (t < 8) chk($sformatf("str_rdy_t%0d", t), 32'(s_ready), 1);
            chk($sformatf("str_vld_t%0d", t), 32'(m_valid), 32'(t == 9 || t == 13));
            if (t == 9 || t == 13) begin
                chk($sformatf("str_data_t%0d", t), 32'(m_data), 32'h0040);
                chk($sformatf("str_idx_t%0d", t), 32'(m_index), 32'(t == 13));
            end
            nxt();
        end

        // backpressure: m_ready low for 6 cycles after the first result
        do_clear();
        for (int t = 0; t < 23; t++) begin
            if (t < 8) beat(16'h0001, 128'h0010); else idle();
            m_ready = !(t >= 9 && t <= 14);
            @(negedge clk);
            chk($sformatf("bp_vld_t%0d", t), 32'(m_valid), 32'((t >= 9 && t <= 15) || t == 19));
            if (t >= 9 && t <= 14) begin
                chk($sformatf("bp_pe_en_t%0d", t), 32'(pe_en), 0);
                chk($sformatf("bp_rdy_t%0d", t), 32'(s_ready), 0);
                chk($sformatf("bp_hold_t%0d", t), 32'(m_data), 32'h0040);
            end
            if (t == 19) begin
                chk("bp_data2", 32'(m_data), 32'h0040);
                chk("bp_idx2", 32'(m_index), 1);
            end
            nxt();
        end
        m_ready = 1'b1;

        // modulo wrap of data and of m_index over 257 neurons
        do_clear();
        k = 0;
        for (int t = 0; t < 1050; t++) begin
            if (t < 1028) beat(16'h0001, 128'hFFF0); else idle();
            @(negedge clk);
            if (m_valid) begin
                if (k == 0) begin
                    chk("wrap_data0", 32'(m_data), 32'hFFC0);
                    chk("wrap_idx0", 32'(m_index), 0);
                end
                if (k == 255) chk("wrap_idx255", 32'(m_index), 255);
                if (k == 256) begin
                    chk("wrap_idx256", 32'(m_index), 0);
                    chk("wrap_data256", 32'(m_data), 32'hFFC0);
                end
                k++;
            end
            nxt();
        end
        chk("wrap_count", 32'(k), 257);

        // clear after two beats of a neuron, with a beat offered that cycle
        do_clear();
        beat(16'h0001, 128'h0010); nxt();
        beat(16'h0001, 128'h0010); nxt();
        clear = 1'b1;
        @(negedge clk);
        chk("clr_pe_clr", 32'(pe_clr), 1);
        chk("clr_s_ready", 32'(s_ready), 0);
        chk("clr_busy_pre", 32'(busy), 1);
        nxt();
        clear = 1'b0; idle();
        @(negedge clk);
        chk("clr_busy_post", 32'(busy), 0);
        nxt();
        one_neuron("clr_fresh", 128'h0010, 16'h0040, 0);

        // rst while a result is stalled
        for (int t = 0; t < 11; t++) begin
            if (t < 4) beat(16'h0001, 128'h0010); else idle();
            m_ready = (t < 9);
            @(negedge clk);
            if (t == 10) begin
                chk("rst_stall_vld", 32'(m_valid), 1);
                chk("rst_stall_data", 32'(m_data), 32'h0040);
            end
            nxt();
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_vld", 32'(m_valid), 0);
        chk("rst_mid_data", 32'(m_data), 0);
        chk("rst_mid_idx", 32'(m_index), 0);
        chk("rst_mid_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
